// File: rtl/gyro_sample_sched.sv
// Periodic three-axis gyro read scheduler. Applies bias correction, saturation and a deadband,
// and estimates bias by averaging CAL_N samples on request.
module gyro_sample_sched #(
   parameter int PERIOD   = 50000,
   parameter int CAL_LOG2 = 4,
   parameter int DB_LO    = -42,
   parameter int DB_HI    = 10,
   parameter int TIMEOUT  = 1000
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               cal_start,
   input  logic               rd_ack,
   input  logic               rd_valid,
   input  logic signed [15:0] rd_data,
   output logic               rd_req,
   output logic signed [15:0] dx,
   output logic signed [15:0] dy,
   output logic signed [15:0] dz,
   output logic               sample_valid,
   output logic               cal_busy,
   output logic               overrun,
   output logic               timeout_err
);

   localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam int WD_W  = $clog2(TIMEOUT + 1);
   localparam int CAL_N = 1 << CAL_LOG2;
   localparam int CC_W  = CAL_LOG2 + 1;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RECV, S_PROC} state_t;

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [WD_W-1:0]    r_wd;
   logic [1:0]         r_axis;
   logic [CC_W-1:0]    r_cal_cnt;
   logic               r_cal_pend;
   logic               r_txn_cal;
   logic signed [15:0] r_raw  [3];
   logic signed [15:0] r_bias [3];
   logic signed [19:0] r_sum  [3];
   logic signed [15:0] r_out  [3];

   logic               w_tick;
   logic signed [15:0] w_v        [3];
   logic signed [19:0] w_sum_next [3];
   logic signed [15:0] w_bias_new [3];

   assign w_tick = (r_cnt == CNT_W'(PERIOD - 1));
   assign dx = r_out[0];
   assign dy = r_out[1];
   assign dz = r_out[2];

   for (genvar gi = 0; gi < 3; gi++) begin : g_axis
      logic signed [16:0] w_diff;
      logic signed [15:0] w_sat;
      assign w_diff = 17'(r_raw[gi]) - 17'(r_bias[gi]);
      assign w_sat  = (w_diff > 17'sd32767)  ? 16'sh7FFF :
                      (w_diff < -17'sd32768) ? 16'sh8000 : w_diff[15:0];
      assign w_v[gi] = (w_sat > DB_LO && w_sat < DB_HI) ? 16'sd0 : w_sat;
      assign w_sum_next[gi] = r_sum[gi] + 20'(r_raw[gi]);
      assign w_bias_new[gi] = 16'(w_sum_next[gi] >>> CAL_LOG2);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_wd         <= '0;
         r_axis       <= '0;
         r_cal_cnt    <= '0;
         r_cal_pend   <= 1'b0;
         r_txn_cal    <= 1'b0;
         rd_req       <= 1'b0;
         sample_valid <= 1'b0;
         cal_busy     <= 1'b0;
         overrun      <= 1'b0;
         timeout_err  <= 1'b0;
         for (int i = 0; i < 3; i++) begin
            r_raw[i]  <= '0;
            r_bias[i] <= '0;
            r_sum[i]  <= '0;
            r_out[i]  <= '0;
         end
      end else begin
         sample_valid <= 1'b0;
         r_cnt        <= w_tick ? '0 : r_cnt + 1'b1;
         if (w_tick && r_state != S_IDLE)
            overrun <= 1'b1;

         case (r_state)
            S_IDLE: begin
               if (w_tick) begin
                  r_state   <= S_REQ;
                  rd_req    <= 1'b1;
                  r_wd      <= '0;
                  r_txn_cal <= r_cal_pend;
               end
            end
            S_REQ, S_RECV: begin
               // Watchdog abort drops the partial transaction before it can reach PROC
               if (r_wd == WD_W'(TIMEOUT - 1)) begin
                  timeout_err <= 1'b1;
                  rd_req      <= 1'b0;
                  r_state     <= S_IDLE;
               end else begin
                  r_wd <= r_wd + 1'b1;
                  if (r_state == S_REQ) begin
                     if (rd_ack) begin
                        rd_req  <= 1'b0;
                        r_axis  <= '0;
                        r_state <= S_RECV;
                     end
                  end else if (rd_valid) begin
                     for (int i = 0; i < 3; i++)
                        if (r_axis == 2'(i)) r_raw[i] <= rd_data;
                     r_axis <= r_axis + 1'b1;
                     if (r_axis == 2'd2) r_state <= S_PROC;
                  end
               end
            end
            S_PROC: begin
               r_state <= S_IDLE;
               if (r_txn_cal) begin
                  for (int i = 0; i < 3; i++) r_sum[i] <= w_sum_next[i];
                  if (r_cal_cnt == CC_W'(CAL_N - 1)) begin
                     for (int i = 0; i < 3; i++) r_bias[i] <= w_bias_new[i];
                     cal_busy   <= 1'b0;
                     r_cal_pend <= 1'b0;
                     r_txn_cal  <= 1'b0;
                     r_cal_cnt  <= '0;
                  end else begin
                     r_cal_cnt <= r_cal_cnt + 1'b1;
                  end
               end else begin
                  for (int i = 0; i < 3; i++) r_out[i] <= w_v[i];
                  sample_valid <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase

         // A new request restarts accumulation; an in-flight transaction is not counted
         if (cal_start) begin
            cal_busy   <= 1'b1;
            r_cal_pend <= 1'b1;
            r_txn_cal  <= 1'b0;
            r_cal_cnt  <= '0;
            for (int i = 0; i < 3; i++) r_sum[i] <= '0;
         end
      end
   end

endmodule

// File: tb/tb_gyro_sample_sched.sv
// Scoreboard bench for gyro_sample_sched: models the reader handshake and predicts
// corrected rates from its own bias/saturation/deadband model.
module tb_gyro_sample_sched;

   logic               CLK = 1'b0;
   logic               RST;
   logic               cal_start;
   logic               rd_ack;
   logic               rd_valid;
   logic signed [15:0] rd_data;
   logic               rd_req;
   logic signed [15:0] dx, dy, dz;
   logic               sample_valid;
   logic               cal_busy;
   logic               overrun;
   logic               timeout_err;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      int x;
      int y;
      int z;
   } exp_t;
   exp_t sb[$];
   int   bias_m[3];

   gyro_sample_sched #(.PERIOD(100), .CAL_LOG2(2)) dut (
      .CLK(CLK), .RST(RST), .cal_start(cal_start), .rd_ack(rd_ack),
      .rd_valid(rd_valid), .rd_data(rd_data), .rd_req(rd_req),
      .dx(dx), .dy(dy), .dz(dz), .sample_valid(sample_valid),
      .cal_busy(cal_busy), .overrun(overrun), .timeout_err(timeout_err)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int model(input int raw, input int bias);
      int v;
      v = raw - bias;
      if (v > 32767) v = 32767;
      else if (v < -32768) v = -32768;
      if (v > -42 && v < 10) v = 0;
      return v;
   endfunction

   always @(negedge CLK) begin
      if (!RST && sample_valid) begin
         if (sb.size() == 0) begin
            check("unexpected_sample_valid", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("dx", int'(dx), e.x);
            check("dy", int'(dy), e.y);
            check("dz", int'(dz), e.z);
            $display("sample dx=%0d dy=%0d dz=%0d", dx, dy, dz);
         end
      end
   end

   task automatic wait_req();
      int n = 0;
      while (!rd_req && n < 300) begin
         @(negedge CLK);
         n++;
      end
      check("req_seen", int'(rd_req), 1);
   endtask

   task automatic do_txn(input int ack_dly, input int x, input int y, input int z,
                         input int z_gap, input bit exp_sv);
      if (exp_sv) sb.push_back('{model(x, bias_m[0]), model(y, bias_m[1]), model(z, bias_m[2])});
      wait_req();
      repeat (ack_dly) @(posedge CLK);
      #1 rd_ack = 1'b1;
      @(posedge CLK);
      #1 rd_ack = 1'b0;
      rd_valid = 1'b1;
      rd_data  = 16'(x);
      @(posedge CLK);
      #1 rd_data = 16'(y);
      @(posedge CLK);
      #1;
      if (z_gap > 0) begin
         rd_valid = 1'b0;
         repeat (z_gap) @(posedge CLK);
         #1;
      end
      rd_valid = 1'b1;
      rd_data  = 16'(z);
      @(posedge CLK);
      #1 rd_valid = 1'b0;
      @(negedge CLK);
      check("sv_early", int'(sample_valid), 0);
      @(negedge CLK);
      check("sv_latency", int'(sample_valid), int'(exp_sv));
      $display("txn x=%0d y=%0d z=%0d exp_sv=%0b", x, y, z, exp_sv);
   endtask

   task automatic pulse_cal();
      @(posedge CLK);
      #1 cal_start = 1'b1;
      @(posedge CLK);
      #1 cal_start = 1'b0;
      @(negedge CLK);
      check("cal_busy_set", int'(cal_busy), 1);
   endtask

   task automatic cal_run(input int xs[4], input int ys[4], input int zs[4]);
      int s[3] = '{0, 0, 0};
      for (int k = 0; k < 4; k++) begin
         do_txn(1, xs[k], ys[k], zs[k], 0, 1'b0);
         s[0] += xs[k];
         s[1] += ys[k];
         s[2] += zs[k];
         if (k < 3) check("cal_busy_mid", int'(cal_busy), 1);
      end
      check("cal_busy_done", int'(cal_busy), 0);
      for (int i = 0; i < 3; i++) bias_m[i] = s[i] >>> 2;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      int n;
      bias_m    = '{0, 0, 0};
      RST       = 1'b1;
      cal_start = 1'b0;
      rd_ack    = 1'b0;
      rd_valid  = 1'b0;
      rd_data   = '0;
      repeat (3) @(posedge CLK);
      #1 RST = 1'b0;
      @(negedge CLK);
      check("rst_rd_req", int'(rd_req), 0);
      check("rst_sv", int'(sample_valid), 0);
      check("rst_cal_busy", int'(cal_busy), 0);
      check("rst_overrun", int'(overrun), 0);
      check("rst_timeout", int'(timeout_err), 0);
      check("rst_dx", int'(dx), 0);

      // Basic sample with Z inside the deadband
      do_txn(3, 500, -300, 5, 0, 1'b1);
      repeat (5) @(negedge CLK);
      check("hold_dx", int'(dx), 500);
      check("hold_dy", int'(dy), -300);
      check("hold_dz", int'(dz), 0);

      // Stray ack and valid while idle must be ignored
      #1 rd_ack = 1'b1;
      rd_valid  = 1'b1;
      rd_data   = 16'sd1234;
      @(posedge CLK);
      #1 rd_ack = 1'b0;
      rd_valid  = 1'b0;

      // Calibration: X average 101
      pulse_cal();
      cal_run('{100, 102, 98, 104}, '{0, 0, 0, 0}, '{0, 0, 0, 0});
      do_txn(2, 151, 9, -42, 0, 1'b1);
      do_txn(0, 111, 10, -41, 0, 1'b1);

      // Z strobe delayed past the next tick
      check("overrun_clear", int'(overrun), 0);
      do_txn(1, 300, -50, 42, 110, 1'b1);
      check("overrun_set", int'(overrun), 1);

      // Watchdog: never acknowledge
      wait_req();
      n = 0;
      while (!timeout_err && n < 1500) begin
         @(negedge CLK);
         n++;
      end
      check("timeout_cycles", n, 1000);
      check("timeout_rd_req", int'(rd_req), 0);
      do_txn(1, -1000, 20, -43, 0, 1'b1);
      check("timeout_sticky", int'(timeout_err), 1);

      // Restarted calibration, then saturation in both directions
      pulse_cal();
      do_txn(1, 5000, 5000, 5000, 0, 1'b0);
      do_txn(1, 5000, 5000, 5000, 0, 1'b0);
      pulse_cal();
      cal_run('{100, 100, 100, 100}, '{-4, -4, -4, -4}, '{-3, -2, -2, -2});
      do_txn(1, -32768, 32767, 7, 0, 1'b1);

      // Reset between X and Y strobes
      wait_req();
      @(posedge CLK);
      #1 rd_ack = 1'b1;
      @(posedge CLK);
      #1 rd_ack = 1'b0;
      rd_valid  = 1'b1;
      rd_data   = 16'sd777;
      @(posedge CLK);
      #1 rd_valid = 1'b0;
      RST = 1'b1;
      @(posedge CLK);
      #1 RST = 1'b0;
      bias_m = '{0, 0, 0};
      @(negedge CLK);
      check("mid_rst_dx", int'(dx), 0);
      check("mid_rst_dy", int'(dy), 0);
      check("mid_rst_dz", int'(dz), 0);
      check("mid_rst_rd_req", int'(rd_req), 0);
      check("mid_rst_overrun", int'(overrun), 0);
      check("mid_rst_timeout", int'(timeout_err), 0);
      check("mid_rst_cal_busy", int'(cal_busy), 0);
      // Leftover Y/Z strobes after reset are ignored
      #1 rd_valid = 1'b1;
      rd_data = 16'sd888;
      @(posedge CLK);
      #1 rd_data = 16'sd999;
      @(posedge CLK);
      #1 rd_valid = 1'b0;
      do_txn(2, 500, -300, 5, 0, 1'b1);

      repeat (3) @(negedge CLK);
      check("sb_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
